// File: rtl/fifo_write_ctrl.sv
// Write side of an async FIFO: zero-latency dpram write on valid&&ready, Gray pointer out, full/level/almost_full.
// Backpressure via write_ready (low when full); optional FIFO_READ_POINTER_SYNC_EN adds a 2-flop read-pointer synchronizer.
module fifo_write_ctrl #(
   parameter int ADDR_WIDTH        = 8,
   parameter int DATA_WIDTH        = 8,
   parameter int ALMOST_FULL_LEVEL = 2**ADDR_WIDTH - 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  write_valid,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  write_ready,
   input  logic [ADDR_WIDTH:0]   read_pointer_gray,
   output logic [ADDR_WIDTH:0]   write_pointer_gray,
   output logic [ADDR_WIDTH-1:0] ram_write_address,
   output logic [DATA_WIDTH-1:0] ram_write_data,
   output logic                  ram_write,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  almost_full,
   output logic                  overflow
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);

   logic [PW-1:0] wbin;
   logic [PW-1:0] wgray;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] rsync;
   logic [PW-1:0] rbin;
   logic          full;
   logic          accept;

`ifdef FIFO_READ_POINTER_SYNC_EN
   logic [PW-1:0] sync_1;
   logic [PW-1:0] sync_2;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= read_pointer_gray;
         sync_2 <= sync_1;
      end
   end

   assign rsync = sync_2;
`else
   assign rsync = read_pointer_gray;
`endif

   always_comb begin
      rbin = '0;
      for (int i = 0; i < PW; i++) begin
         rbin[i] = ^(rsync >> i);
      end
   end

   // Full when the pointers match on the address bits but differ in the wrap bit.
   assign full        = (wgray == {~rsync[PW-1:PW-2], rsync[PW-3:0]});
   assign write_ready = !full;
   // Gated by reset so a write in flight cannot reach the RAM while the pointers are cleared.
   assign accept      = write_valid && write_ready && reset_n;
   assign wbin_next   = wbin + PW'(1);

   assign ram_write          = accept;
   assign ram_write_address  = wbin[ADDR_WIDTH-1:0];
   assign ram_write_data     = write_data;
   assign write_pointer_gray = wgray;
   assign level              = wbin - rbin;
   assign almost_full        = (level >= AF_LEVEL);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wbin     <= '0;
         wgray    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            wbin  <= wbin_next;
            wgray <= wbin_next ^ (wbin_next >> 1);
         end
         if (write_valid && full) begin
            overflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Scoreboard bench for fifo_write_ctrl: expected RAM writes queued at drive time, popped on ram_write.
module tb_fifo_write_ctrl;
`ifdef FIFO_READ_POINTER_SYNC_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n;
   logic       write_valid;
   logic [7:0] write_data;
   logic       write_ready;
   logic [8:0] read_pointer_gray;
   logic [8:0] write_pointer_gray;
   logic [7:0] ram_write_address;
   logic [7:0] ram_write_data;
   logic       ram_write;
   logic [8:0] level;
   logic       almost_full;
   logic       overflow;

   fifo_write_ctrl dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .write_valid       (write_valid),
      .write_data        (write_data),
      .write_ready       (write_ready),
      .read_pointer_gray (read_pointer_gray),
      .write_pointer_gray(write_pointer_gray),
      .ram_write_address (ram_write_address),
      .ram_write_data    (ram_write_data),
      .ram_write         (ram_write),
      .level             (level),
      .almost_full       (almost_full),
      .overflow          (overflow)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int wbin_m = 0;
   int rp_now = 0;
   int rp_d1  = 0;
   int rp_d2  = 0;
   int ovf_m  = 0;
   int last_addr = -1;
   int sb_q[$];

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int gray(input int b);
      return (b ^ (b >> 1)) & 511;
   endfunction

   // One cycle: drive at posedge+1, compare at the falling edge, advance the model after the edge.
   task automatic step(input logic v, input logic [7:0] d);
      int rvis, lvl, exp_wr, exp_full, ent;
      write_valid       = v;
      write_data        = d;
      read_pointer_gray = 9'(gray(rp_now));
      rvis     = SYNC_EN ? rp_d2 : rp_now;
      lvl      = (wbin_m - rvis) & 511;
      exp_full = (lvl == 256) ? 1 : 0;
      exp_wr   = (v && !exp_full) ? 1 : 0;
      if (exp_wr != 0) sb_q.push_back(((wbin_m & 255) << 8) | int'(d));
      #4;
      check_eq("ram_write", int'(ram_write), exp_wr);
      check_eq("write_ready", int'(write_ready), 1 - exp_full);
      check_eq("level", int'(level), lvl);
      check_eq("almost_full", int'(almost_full), (lvl >= 252) ? 1 : 0);
      check_eq("wptr_gray", int'(write_pointer_gray), gray(wbin_m));
      check_eq("overflow", int'(overflow), ovf_m);
      if (ram_write) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_write", 1, 0);
         end else begin
            ent = sb_q.pop_front();
            check_eq("ram_addr", int'(ram_write_address), ent >> 8);
            check_eq("ram_data", int'(ram_write_data), ent & 255);
            last_addr = int'(ram_write_address);
         end
      end
      @(posedge clock);
      #1;
      if (exp_wr != 0) wbin_m = (wbin_m + 1) & 511;
      if (v && exp_full != 0) ovf_m = 1;
      rp_d2 = rp_d1;
      rp_d1 = rp_now;
   endtask

   task automatic model_reset();
      wbin_m = 0; rp_now = 0; rp_d1 = 0; rp_d2 = 0; ovf_m = 0;
      sb_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ram_write"}, int'(ram_write), 0);
      check_eq({tag, "_wptr"}, int'(write_pointer_gray), 0);
      check_eq({tag, "_level"}, int'(level), 0);
      check_eq({tag, "_ready"}, int'(write_ready), 1);
      check_eq({tag, "_afull"}, int'(almost_full), 0);
      check_eq({tag, "_overflow"}, int'(overflow), 0);
   endtask

   initial begin
      reset_n = 1'b0; write_valid = 1'b0; write_data = '0; read_pointer_gray = '0;
      #12;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Four writes from empty.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(i));
      check_eq("wptr_after4", int'(write_pointer_gray), 'h006);
      check_eq("level_after4", int'(level), 4);

      // Fill to 256 with the read pointer held at zero.
      for (int i = 4; i < 256; i++) step(1'b1, 8'(i));
      check_eq("ready_full", int'(write_ready), 0);
      check_eq("wptr_full", int'(write_pointer_gray), 'h180);

      // Write attempt while full sets sticky overflow.
      step(1'b1, 8'hAA);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      check_eq("overflow_sticky", int'(overflow), 1);

      // Free one slot; next accepted write lands at address 0.
      rp_now = 1;
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      step(1'b1, 8'h55);
      check_eq("addr_after_free", last_addr, 0);

      // Reset pulse clears overflow and pointers.
      #2;
      reset_n = 1'b0;
      read_pointer_gray = '0;
      write_valid = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("pulse");
      #2;
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Stream 600 words with the reader trailing 10 behind, across address wrap.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0), 8'(i) ^ 8'h3C);
         rp_now = (wbin_m >= 10 || rp_now > 0) ? ((wbin_m - 10) & 511) : 0;
      end

      // Asynchronous reset while a write is being presented.
      write_valid = 1'b1;
      write_data  = 8'h77;
      read_pointer_gray = '0;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_eq("async_ram_write", int'(ram_write), 0);
      check_eq("async_wptr", int'(write_pointer_gray), 0);
      check_eq("async_ready", int'(write_ready), 1);
      check_eq("async_level", int'(level), 0);
      write_valid = 1'b0;
      #3;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      step(1'b1, 8'h12);
      check_eq("post_reset_addr", last_addr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_write_ctrl.md
FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 8; RAM address width; FIFO depth = 2**ADDR_WIDTH.
REQ-002 Parameter: DATA_WIDTH, default 8; data word width.
REQ-003 Parameter: ALMOST_FULL_LEVEL, default 2**ADDR_WIDTH-4; occupancy at which almost_full asserts.
REQ-004 clock  input  1  write-domain clock; all state is updated on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 write_valid  input  1  producer requests a write of write_data this cycle.
REQ-007 write_data  input  DATA_WIDTH  producer data word.
REQ-008 write_ready  output  1  FIFO not full; a write is accepted when write_valid && write_ready.
REQ-009 read_pointer_gray  input  ADDR_WIDTH+1  Gray-coded read pointer from the read domain.
REQ-010 write_pointer_gray  output  ADDR_WIDTH+1  registered Gray-coded write pointer for the read domain.
REQ-011 ram_write_address  output  ADDR_WIDTH  dpram write address.
REQ-012 ram_write_data  output  DATA_WIDTH  dpram write data.
REQ-013 ram_write  output  1  dpram write enable, sampled by the dpram on the clock rising edge.
REQ-014 level  output  ADDR_WIDTH+1  write-side occupancy estimate, 0..2**ADDR_WIDTH.
REQ-015 almost_full  output  1  level >= ALMOST_FULL_LEVEL.
REQ-016 overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-017 Internal state: binary write pointer wbin (ADDR_WIDTH+1 bits), registered Gray copy wgray = wbin ^ (wbin >> 1).
REQ-018 ram_write_address = wbin[ADDR_WIDTH-1:0]; ram_write_data = write_data (combinational passthrough); ram_write = write_valid && write_ready.
REQ-019 On an accepted write, the word is committed to the dpram and wbin/wgray increment by 1 at the same rising edge; zero added latency.
REQ-020 wbin wraps modulo 2**(ADDR_WIDTH+1); the RAM address wraps modulo 2**ADDR_WIDTH with no gap.
REQ-021 rsync = read pointer as seen by the write domain (see Configuration); rbin = Gray-to-binary of rsync.
REQ-022 full = (wgray == {~rsync[ADDR_WIDTH:ADDR_WIDTH-1], rsync[ADDR_WIDTH-2:0]}); write_ready = !full.
REQ-023 level = (wbin - rbin) modulo 2**(ADDR_WIDTH+1), combinational from registered state.
REQ-024 write_valid while full: no RAM write, pointer unchanged, overflow set at that edge and held until reset.
REQ-025 Read pointer advance and write in the same cycle: write accepted per current full; freed space is visible only after rsync updates.
REQ-026 Full/level are conservative: they may overstate occupancy during sync latency, never understate it.

Reset
REQ-027 reset_n low asynchronously clears wbin, wgray, synchronizer flops and overflow to 0.
REQ-028 During reset: ram_write=0, write_pointer_gray=0, level=0, write_ready=1, almost_full=0.
REQ-029 Reset mid-stream discards unread contents logically; RAM contents are not cleared.

Configuration
REQ-030 Macro FIFO_READ_POINTER_SYNC_EN defined: rsync is read_pointer_gray through a 2-flop synchronizer clocked by clock, reset to 0 by reset_n.
REQ-031 Macro FIFO_READ_POINTER_SYNC_EN undefined: rsync = read_pointer_gray directly (caller guarantees synchronization); full/level react in the same cycle.

Verification
REQ-032 Reset, then write_valid=1 with data 0x00..0x03 for 4 cycles, read_pointer_gray=0 -> ram_write high 4 cycles, addresses 0..3, write_pointer_gray=0x006 (binary 4), level=4.
REQ-033 Write 256 words with read pointer held at 0 -> write_ready=0 after 256th accept, write_pointer_gray=0x180, almost_full=1 from level 252.
REQ-034 While full, write_valid=1 one cycle -> ram_write=0, pointer unchanged, overflow=1 and stays 1 until reset_n pulse.
REQ-035 Full, then read_pointer_gray=0x001 (binary 1) -> with sync enabled write_ready=1 after 2 edges; without, same cycle; next write goes to address 0x00.
REQ-036 Stream 600 words with read pointer tracking 10 behind -> addresses wrap 0xFF->0x00, no ram_write while full, level never exceeds 256.
REQ-037 Assert reset_n low mid-write, asynchronously between edges -> ram_write and pointers go to 0 immediately, write_ready=1.
